intr_entry_sequencer: RTL

- Sequences the CPU's hardware interrupt entry.
- Samples the latched interrupt pending flag from the ports/interrupt block and waits for a CU-signalled instruction boundary.
- Stalls the pipeline while it drains, pushes the return PC to the data-memory stack, then fetches the ISR vector from a fixed memory address.
- Loads the vector into the PC and pulses intr_clear back to the ports block. Blocks nested interrupts until the CU reports RTI.

---
 rtl/intr_entry_sequencer_if.sv | 68 ++++++
 rtl/intr_entry_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/intr_entry_sequencer_if.sv
// Bundle of the CU / ports-block / data-memory signals seen by the
// interrupt entry sequencer. "master" is the sequencer side, "slave" is
// the surrounding CPU (control unit, ports block and data memory).
interface intr_entry_sequencer_if;
    // Requests and status coming into the sequencer
    logic       intr_flag;
    logic       instr_boundary;
    logic       rti_done;
    logic [7:0] pc_in;
    logic [7:0] sp_in;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    // Pipeline, memory and PC controls driven by the sequencer
    logic       stall;
    logic       flush;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       sp_dec;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       intr_clear;
    logic       in_isr;

    modport master (
        input  intr_flag,
        input  instr_boundary,
        input  rti_done,
        input  pc_in,
        input  sp_in,
        input  mem_ack,
        input  mem_rdata,
        output stall,
        output flush,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output sp_dec,
        output pc_load,
        output pc_load_val,
        output intr_clear,
        output in_isr
    );

    modport slave (
        output intr_flag,
        output instr_boundary,
        output rti_done,
        output pc_in,
        output sp_in,
        output mem_ack,
        output mem_rdata,
        input  stall,
        input  flush,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  sp_dec,
        input  pc_load,
        input  pc_load_val,
        input  intr_clear,
        input  in_isr
    );
endinterface

// File: rtl/intr_entry_sequencer.sv
// Hardware interrupt entry sequencer.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a pending interrupt at an instruction boundary
//   DRAIN | pipeline frozen while in-flight work drains (first cycle flushes)
//   PUSH  | writing the return PC to the stack at SP
//   VEC   | reading the ISR start address from VEC_ADDR
//   JUMP  | loading the PC with the vector, clearing the pending flag
//
// Every output is a register written on the same edge as the state
// transition, so nothing combinational runs from the inputs to the outputs.
// The stack address is captured from sp_in on entry to PUSH and held
// until the write is acknowledged.
module intr_entry_sequencer #(
    parameter logic [7:0]  VEC_ADDR     = 8'hFF,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input logic                     clk,
    input logic                     rst,
    intr_entry_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        PUSH  = 3'd2,
        VEC   = 3'd3,
        JUMP  = 3'd4
    } state_t;

    // The counter is loaded with N-1 so that the DRAIN dwell is exactly N cycles.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] counter;
    logic [7:0] ret_pc;
    logic [7:0] vector;

    // The last fetched vector stays visible after JUMP.
    assign bus.pc_load_val = vector;

    // Sequencer state, internal registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            counter        <= 4'd0;
            ret_pc         <= 8'h00;
            vector         <= 8'h00;
            bus.stall      <= 1'b0;
            bus.flush      <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= 8'h00;
            bus.mem_wdata  <= 8'h00;
            bus.sp_dec     <= 1'b0;
            bus.pc_load    <= 1'b0;
            bus.intr_clear <= 1'b0;
            bus.in_isr     <= 1'b0;
        end else begin
            // Single-cycle pulses return low unless a transition below raises them.
            bus.flush      <= 1'b0;
            bus.sp_dec     <= 1'b0;
            bus.pc_load    <= 1'b0;
            bus.intr_clear <= 1'b0;

            // RTI releases the mask; the JUMP branch below overrides it when both coincide.
            if (bus.rti_done) begin
                bus.in_isr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.intr_flag && bus.instr_boundary && !bus.in_isr) begin
                        ret_pc    <= bus.pc_in;
                        counter   <= DRAIN_LOAD;
                        state     <= DRAIN;
                        bus.stall <= 1'b1;
                        bus.flush <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (counter == 4'd0) begin
                        state         <= PUSH;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.sp_in;
                        bus.mem_wdata <= ret_pc;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end

                PUSH: begin
                    if (bus.mem_ack) begin
                        state         <= VEC;
                        bus.sp_dec    <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= VEC_ADDR;
                        bus.mem_wdata <= 8'h00;
                    end
                end

                VEC: begin
                    if (bus.mem_ack) begin
                        vector         <= bus.mem_rdata;
                        state          <= JUMP;
                        bus.stall      <= 1'b0;
                        bus.mem_req    <= 1'b0;
                        bus.mem_addr   <= 8'h00;
                        bus.pc_load    <= 1'b1;
                        bus.intr_clear <= 1'b1;
                    end
                end

                JUMP: begin
                    bus.in_isr <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    state         <= IDLE;
                    bus.stall     <= 1'b0;
                    bus.mem_req   <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= 8'h00;
                    bus.mem_wdata <= 8'h00;
                end
            endcase
        end
    end

endmodule
